// File: rtl/mem_pkg.sv
// Shared types and the byte-to-bank lane mapping for the dual-bank (even/odd) memory front end.
package mem_pkg;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } req_size_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [14:0] even_addr;
        logic [14:0] odd_addr;
        logic        even_en;
        logic        odd_en;
        logic        swap;
    } lane_map_t;

    typedef struct packed {
        logic      valid;
        req_size_t size;
        logic      swap;
        logic      write;
        logic      err;
    } inflight_t;

    function automatic lane_map_t lane_map(input logic [15:0] addr, input req_size_t size);
        lane_map_t   m;
        logic [14:0] w;
        w      = addr[15:1];
        m      = '0;
        m.swap = addr[0];
        if (size == SIZE_WORD) begin
            m.even_en  = 1'b1;
            m.odd_en   = 1'b1;
            m.odd_addr = w;
            // Unaligned high byte lives in the next even word; 0x7FFF wraps to 0x0000.
            m.even_addr = addr[0] ? w + 15'd1 : w;
        end else if (addr[0]) begin
            m.odd_en   = 1'b1;
            m.odd_addr = w;
        end else begin
            m.even_en   = 1'b1;
            m.even_addr = w;
        end
        return m;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous response FIFO; a push and a pop in the same cycle are accepted even when full.
module rsp_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = logic
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CntW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        count = count_q;
    end

endmodule

// File: rtl/mem_access.sv
// Byte-addressed load/store front end: splits requests onto the even/odd banks, blocks ROM stores,
// reassembles read data one cycle later and returns in-order responses through rsp_fifo.
module mem_access #(
    parameter logic [15:0] ROMBASE = 16'h4000,
    parameter int unsigned DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [14:0] read_addr_even,
    output logic [14:0] read_addr_odd,
    input  logic [7:0]  read_data_even,
    input  logic [7:0]  read_data_odd,
    output logic [14:0] write_addr_even,
    output logic [14:0] write_addr_odd,
    output logic [7:0]  write_data_even,
    output logic [7:0]  write_data_odd,
    output logic        write_en_even,
    output logic        write_en_odd
);

    import mem_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    req_size_t       req_size;
    lane_map_t       lanes;
    logic [15:0]     addr_hi;
    logic            rom_hit;
    logic            accept;
    logic            pop;
    logic [CntW-1:0] count;
    logic [OccW-1:0] occ_next;
    inflight_t       inflight_q, inflight_d;
    rsp_t            push_rsp, head;
    logic [7:0]      lo_byte, hi_byte;

    // The in-flight entry is counted against capacity so it always has a FIFO slot next edge.
    always_comb begin
        rsp_valid = (count != '0);
        rsp_rdata = head.rdata;
        rsp_err   = head.err;
        pop       = rsp_valid && rsp_ready;
        occ_next  = OccW'(count) + OccW'(inflight_q.valid) - OccW'(pop);
        req_ready = !reset && (occ_next < OccW'(DEPTH));
        accept    = req_valid && req_ready;
    end

    always_comb begin
        req_size = req_word ? SIZE_WORD : SIZE_BYTE;
        lanes    = lane_map(req_addr, req_size);
        addr_hi  = req_addr + 16'd1;
        rom_hit  = (req_addr >= ROMBASE) || (req_word && (addr_hi >= ROMBASE));

        read_addr_even  = '0;
        read_addr_odd   = '0;
        write_addr_even = '0;
        write_addr_odd  = '0;
        write_data_even = '0;
        write_data_odd  = '0;
        write_en_even   = 1'b0;
        write_en_odd    = 1'b0;

        if (accept && !req_write) begin
            read_addr_even = lanes.even_addr;
            read_addr_odd  = lanes.odd_addr;
        end
        if (accept && req_write) begin
            write_addr_even = lanes.even_addr;
            write_addr_odd  = lanes.odd_addr;
            if (lanes.even_en) begin
                write_data_even = (req_word && lanes.swap) ? req_wdata[15:8] : req_wdata[7:0];
            end
            if (lanes.odd_en) begin
                write_data_odd = (req_word && !lanes.swap) ? req_wdata[15:8] : req_wdata[7:0];
            end
            write_en_even = lanes.even_en && !rom_hit;
            write_en_odd  = lanes.odd_en && !rom_hit;
        end
    end

    always_comb begin
        inflight_d = '0;
        if (accept) begin
            inflight_d.valid = 1'b1;
            inflight_d.size  = req_size;
            inflight_d.swap  = lanes.swap;
            inflight_d.write = req_write;
            inflight_d.err   = req_write && rom_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Bank data arrives this cycle for the request accepted at the previous edge.
    always_comb begin
        lo_byte  = inflight_q.swap ? read_data_odd : read_data_even;
        hi_byte  = inflight_q.swap ? read_data_even : read_data_odd;
        push_rsp = '0;
        if (inflight_q.write) begin
            push_rsp.err = inflight_q.err;
        end else if (inflight_q.size == SIZE_WORD) begin
            push_rsp.rdata = {hi_byte, lo_byte};
        end else begin
            push_rsp.rdata = {8'h00, lo_byte};
        end
    end

    rsp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q.valid),
        .push_data (push_rsp),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: doc/mem_access.md
# mem_access

Byte-addressed load/store front end for the dual-bank (even/odd) memory subsystem. It takes one CPU request per cycle with a 16-bit byte address and a byte or word size, and splits it into even-bank and odd-bank port accesses, including unaligned words and the 0xFFFF→0x0000 wrap. It reassembles read data after the memory's 1-cycle read latency and suppresses writes that touch ROM. Responses are returned in order through a small response FIFO with back-pressure.

## Interface
- ROMBASE, 16'h4000, first byte address of ROM; must match the memory instance.
- DEPTH, 2, response FIFO depth (≥2).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_write  in  1  1 = store, 0 = load.
- req_word  in  1  1 = 16-bit, 0 = 8-bit.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; bits [7:0] for byte stores.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  response consumed when valid && ready.
- rsp_rdata  out  16  load data; 0 for stores.
- rsp_err  out  1  store suppressed (ROM hit).
- read_addr_even / read_addr_odd  out  15  bank read word addresses.
- read_data_even / read_data_odd  in  8  bank read data, valid the cycle after the address.
- write_addr_even / write_addr_odd  out  15  bank write word addresses.
- write_data_even / write_data_odd  out  8  bank write data.
- write_en_even / write_en_odd  out  1  bank write strobes.

## Operation
- Little-endian: low byte at A, high byte at A+1. W = A[15:1].
- Byte, A[0]=0: even bank at W. Byte, A[0]=1: odd bank at W.
- Word, A[0]=0: low byte from even bank at W, high byte from odd bank at W.
- Word, A[0]=1: low byte from odd bank at W, high byte from even bank at (W+1) mod 2^15. A=0xFFFF gives odd 0x7FFF (low) and even 0x0000 (high).
- Bank ports are driven combinationally from the request in the accept cycle. Unused ports have addresses 0, data 0 and write enable 0.
- Store protection: if any addressed byte is ≥ ROMBASE, both write enables stay 0 and the response has rsp_err=1. This covers word 0x3FFF (high byte in ROM) and word 0xFFFF (low byte in ROM).
- Loads never err. ROM and RAM reads both return data.
- Each accepted request produces exactly one response, in order.
- Load response: rdata = {hi, lo} for words, {8'h00, lo} for bytes.
- Store response: rdata = 0, err as above.
- In-flight register holds valid, size and lane swap (the A[0] bit) for one cycle. Its data is assembled and pushed into the FIFO at the next edge.
- req_ready = !reset && (occupancy + inflight − pop) < DEPTH, where pop = rsp_valid && rsp_ready. This is a combinational path from rsp_ready to req_ready.
- Reset: FIFO is emptied and the in-flight entry is discarded. After reset, rsp_valid=0, rsp_rdata=0, rsp_err=0. While reset is high, req_ready=0 and both write enables are 0.

## Timing
- Accept at edge N: the store commits at edge N (strobes are high in cycle N−1…N, i.e. the accept cycle).
- Bank read data is sampled in cycle N+1. The FIFO push occurs at edge N+1, and rsp_valid is visible from cycle N+2. Load-to-response latency is 2 cycles.
- With rsp_ready held high, the block sustains 1 request per cycle with DEPTH=2.
- Same-cycle push and pop with the FIFO full is legal; occupancy is unchanged.
- rsp_ready=0: the FIFO fills and req_ready drops once occupancy + inflight = DEPTH. The in-flight entry is always guaranteed a slot.
- Store followed by a load of the same byte on the next cycle returns the new data, because the banks write on the edge before the read is sampled.

## Structure
- mem_pkg contains:
  - req_size_t enum (SIZE_BYTE, SIZE_WORD);
  - rsp_t struct {rdata[15:0], err};
  - lane-mapping function returning even/odd word addresses and swap flag from (addr, word).
- Sub-module rsp_fifo #(DEPTH, rsp_t): synchronous FIFO with push/pop/occupancy, and simultaneous push+pop when full.

## Test plan
- Aligned word store 0x0010 ← 0xBEEF, then word load 0x0010 → rdata=0xBEEF, err=0. Even bank at 0x0008 holds 0xEF, odd bank 0x0008 holds 0xBE.
- Unaligned word store 0x0021 ← 0x1234 → odd[0x0010]=0x34, even[0x0011]=0x12. Byte load 0x0022 → 0x0012.
- Word store 0x3FFF ← 0xAAAA → no write strobes, rsp_err=1. RAM byte 0x3FFE is unchanged.
- Word load 0xFFFF → read_addr_odd=0x7FFF, read_addr_even=0x0000. Response is {mem[0x0000], rom[0xFFFF]}.
- Back-to-back loads with rsp_ready=0 → req_ready falls after 2 accepts. Releasing rsp_ready drains the responses in order and restores 1/cycle throughput.
- Reset asserted with 1 in flight and 1 queued → after reset, rsp_valid=0. The first new load returns its own data only.
